// File: rtl/pipeline_pkg.sv
// Shared types and width helpers for the pipeline credit sink.
package pipeline_pkg;

    typedef enum logic {DRAIN, RUN} sink_state_t;

    // Bits needed to hold the values 0..n inclusive (counters that can reach n).
    function automatic int count_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sink_fifo_mem.sv
// Ring-buffer storage for the credit sink with a registered read port.
// The read port forwards a same-cycle write to the addressed slot so a push into an empty FIFO shows up one cycle later.
module sink_fifo_mem
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    localparam int AW        = ptr_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_ptr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_ptr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (wr_en && (wr_ptr == rd_ptr)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_ptr];
        end
    end

endmodule

// File: rtl/pipeline_credit_sink.sv
// Credit-issuing sink at the tail of a fixed-latency, non-stallable pipeline.
// Define PIPELINE_SINK_STATUS_EN to add the fifo_count / credits_out status outputs.
module pipeline_credit_sink
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PIPELINE_N = 4,
    parameter int FIFO_DEPTH = 8,
    localparam int CW        = count_w(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic                  pipe_valid,
    input  logic [DATA_WIDTH-1:0] pipe_data,
    output logic                  dout_valid,
    output logic [DATA_WIDTH-1:0] dout_data,
    input  logic                  dout_ready,
`ifdef PIPELINE_SINK_STATUS_EN
    output logic [CW-1:0]         fifo_count,
    output logic [CW-1:0]         credits_out,
`endif
    output logic                  overflow
);

    localparam int AW = ptr_w(FIFO_DEPTH);
    localparam int DW = count_w(PIPELINE_N);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPELINE_N - 1);

    sink_state_t   state, state_next;
    logic [DW-1:0] drain_cnt, drain_cnt_next;
    logic [CW-1:0] credits, count;
    logic [AW-1:0] wr_ptr, rd_ptr, rd_addr;
    logic          in_run, full, issue, pop, push, drop;

    // Stale tags left in the unreset pipeline are flushed during DRAIN.
    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        src_ready      = 1'b0;
        case (state)
            DRAIN: begin
                drain_cnt_next = drain_cnt + DW'(1);
                if (drain_cnt == DRAIN_LAST) state_next = RUN;
            end
            RUN: src_ready = (credits != '0);
            default: state_next = DRAIN;
        endcase
    end

    assign in_run     = (state == RUN);
    assign dout_valid = (count != '0);
    assign full       = (count == DEPTH_C);
    assign issue      = src_valid & src_ready;
    assign pop        = dout_valid & dout_ready;
    assign push       = in_run & pipe_valid & (~full | pop);
    assign drop       = in_run & pipe_valid & full & ~pop;
    // Look-ahead read address keeps the registered head aligned with a pop.
    assign rd_addr    = pop ? rd_ptr + AW'(1) : rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DRAIN;
            drain_cnt <= '0;
            credits   <= DEPTH_C;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
            credits   <= credits - CW'(issue) + CW'(pop);
            count     <= count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_addr;
            if (drop) overflow <= 1'b1;
        end
    end

    sink_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_ptr  (wr_ptr),
        .wr_data (pipe_data),
        .rd_ptr  (rd_addr),
        .rd_data (dout_data)
    );

`ifdef PIPELINE_SINK_STATUS_EN
    assign fifo_count  = count;
    assign credits_out = credits;
`endif

endmodule

// File: tb/tb_pipeline_credit_sink.sv
// Bench for pipeline_credit_sink: models the upstream shift pipeline and checks the sink against a queue-based model.
module tb_pipeline_credit_sink;

    localparam int W = 8;
    localparam int N = 4;
    localparam int D = 8;
    localparam int CW = $clog2(D + 1);

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         src_valid = 1'b0;
    logic         src_ready;
    logic         pipe_valid = 1'b0;
    logic [W-1:0] pipe_data = '0;
    logic         dout_valid;
    logic [W-1:0] dout_data;
    logic         dout_ready = 1'b0;
    logic         overflow;
`ifdef PIPELINE_SINK_STATUS_EN
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] credits_out;
`endif

    pipeline_credit_sink #(
        .DATA_WIDTH (W),
        .PIPELINE_N (N),
        .FIFO_DEPTH (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .pipe_valid (pipe_valid),
        .pipe_data  (pipe_data),
        .dout_valid (dout_valid),
        .dout_data  (dout_data),
        .dout_ready (dout_ready),
`ifdef PIPELINE_SINK_STATUS_EN
        .fifo_count (fifo_count),
        .credits_out(credits_out),
`endif
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Upstream pipeline (free-running, never reset) and stimulus controls.
    logic         st_v [N];
    logic [W-1:0] st_d [N];
    logic [W-1:0] src_word   = '0;
    logic         seq_words  = 1'b0;
    logic         force_pv   = 1'b0;
    logic [W-1:0] force_data = '0;
    int           n_issued   = 0;

    // Behavioural model of the sink.
    int           m_drain_left;
    int           m_credits;
    logic [W-1:0] m_q [$];
    logic         m_ovf;

    // Last observed DUT outputs.
    logic         obs_src_ready, obs_dout_valid, obs_overflow;
    logic [W-1:0] obs_dout_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_src_ready();
        return (m_drain_left == 0) && (m_credits > 0);
    endfunction

    task automatic model_reset();
        m_drain_left = N;
        m_credits    = D;
        m_q.delete();
        m_ovf        = 1'b0;
    endtask

    task automatic drive_pipe();
        pipe_valid = st_v[N-1] | force_pv;
        pipe_data  = force_pv ? force_data : st_d[N-1];
    endtask

    task automatic env_shift(input logic iss);
        for (int k = N - 1; k > 0; k--) begin
            st_v[k] = st_v[k-1];
            st_d[k] = st_d[k-1];
        end
        st_v[0] = iss;
        st_d[0] = src_word;
        if (iss) n_issued++;
        if (iss && seq_words) src_word = src_word + 8'd1;
        drive_pipe();
    endtask

    // One clock cycle: compare at the falling edge, advance model, shift pipeline after the rising edge.
    task automatic cycle();
        logic iss_env, m_issue, m_pop, m_push;
        drive_pipe();
        @(negedge clk);
        obs_src_ready  = src_ready;
        obs_dout_valid = dout_valid;
        obs_dout_data  = dout_data;
        obs_overflow   = overflow;
        check("src_ready", 32'(src_ready), 32'(m_src_ready()));
        check("dout_valid", 32'(dout_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("dout_data", 32'(dout_data), 32'(m_q[0]));
        check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef PIPELINE_SINK_STATUS_EN
        check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        check("credits_out", 32'(credits_out), 32'(m_credits));
`endif
        iss_env = src_valid & src_ready;
        m_issue = src_valid && m_src_ready();
        m_pop   = (m_q.size() != 0) && dout_ready;
        m_push  = 1'b0;
        if (m_drain_left == 0 && pipe_valid) begin
            if (m_q.size() < D || m_pop) m_push = 1'b1;
            else m_ovf = 1'b1;
        end
        if (m_pop) m_q.delete(0);
        if (m_push) m_q.push_back(pipe_data);
        m_credits = m_credits + int'(m_pop) - int'(m_issue);
        if (m_drain_left > 0) m_drain_left--;
        @(posedge clk);
        #1;
        env_shift(iss_env);
    endtask

    // Called just after a rising edge; checks outputs clear with no clock edge in between.
    task automatic async_reset();
        #1 rst = 1'b1;
        #1;
        check("async_src_ready", 32'(src_ready), 32'd0);
        check("async_dout_valid", 32'(dout_valid), 32'd0);
        check("async_dout_data", 32'(dout_data), 32'd0);
        check("async_overflow", 32'(overflow), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        env_shift(1'b0);
        rst = 1'b0;
    endtask

    task automatic drain_timeline(input string tag);
        for (int i = 0; i < 5; i++) begin
            force_pv   = (i == 1) || (i == 3);
            force_data = 8'hEE;
            cycle();
            check({tag, "_src_ready"}, 32'(obs_src_ready), 32'(i == 4));
        end
        force_pv = 1'b0;
    endtask

    initial begin
        int lat;
        for (int k = 0; k < N; k++) begin
            st_v[k] = 1'b1;
            st_d[k] = 8'hD0 + 8'(k);
        end
        model_reset();
        #1;
        async_reset();

        // DRAIN with stale tags and forced garbage, then fill to full.
        src_valid = 1'b1;
        dout_ready = 1'b0;
        seq_words = 1'b1;
        src_word = 8'h00;
        n_issued = 0;
        drain_timeline("drain0");
        for (int i = 5; i <= 16; i++) cycle();
        check("fill_issues", 32'(n_issued), 32'd8);
        check("fill_src_ready", 32'(obs_src_ready), 32'd0);
        check("fill_dout_valid", 32'(obs_dout_valid), 32'd1);
        check("fill_head", 32'(obs_dout_data), 32'h00);
        check("fill_overflow", 32'(obs_overflow), 32'd0);

        // Drain from full at one word per cycle, in order.
        src_valid = 1'b0;
        dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("stream_valid", 32'(obs_dout_valid), 32'd1);
            check("stream_data", 32'(obs_dout_data), 32'(i));
        end
        cycle();
        check("stream_empty", 32'(obs_dout_valid), 32'd0);

        // Issue-to-dout latency into an empty sink.
        seq_words = 1'b0;
        src_word = 8'hA5;
        src_valid = 1'b1;
        cycle();
        check("lat_issue", 32'(obs_src_ready), 32'd1);
        src_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            lat++;
            if (obs_dout_valid) break;
        end
        check("lat_cycles", 32'(lat), 32'd5);
        check("lat_data", 32'(obs_dout_data), 32'hA5);

        // Randomized traffic with varying downstream backpressure.
        for (int i = 0; i < 600; i++) begin
            src_valid  = ($urandom_range(0, 3) != 0);
            dout_ready = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            src_word   = 8'($urandom);
            cycle();
        end

        // Empty the sink, then refill with a known sequence.
        src_valid = 1'b0;
        dout_ready = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        seq_words = 1'b1;
        src_word = 8'h10;
        src_valid = 1'b1;
        dout_ready = 1'b0;
        for (int i = 0; i < 16; i++) cycle();
        check("refill_valid", 32'(obs_dout_valid), 32'd1);
        check("refill_head", 32'(obs_dout_data), 32'h10);
        src_valid = 1'b0;

        // Full FIFO, pipe_valid with a same-cycle pop: push proceeds.
        dout_ready = 1'b1;
        force_pv = 1'b1;
        force_data = 8'h77;
        cycle();
        force_pv = 1'b0;
        dout_ready = 1'b0;
        cycle();
        check("fullpop_overflow", 32'(obs_overflow), 32'd0);
        check("fullpop_head", 32'(obs_dout_data), 32'h11);

        // Full FIFO, pipe_valid with no pop: dropped, overflow sticks.
        force_pv = 1'b1;
        force_data = 8'h3C;
        cycle();
        force_pv = 1'b0;
        cycle();
        check("ovf_set", 32'(obs_overflow), 32'd1);
        for (int i = 0; i < 5; i++) cycle();
        check("ovf_sticky", 32'(obs_overflow), 32'd1);
        check("ovf_head", 32'(obs_dout_data), 32'h11);
        async_reset();

        // Build 3 words in flight and 2 buffered, then reset mid-operation.
        src_valid = 1'b1;
        dout_ready = 1'b0;
        src_word = 8'h40;
        drain_timeline("drain1");
        for (int i = 5; i <= 8; i++) cycle();
        src_valid = 1'b0;
        cycle();
        check("midop_valid", 32'(obs_dout_valid), 32'd1);
        check("midop_head", 32'(obs_dout_data), 32'h40);
        async_reset();

        src_valid = 1'b1;
        dout_ready = 1'b1;
        src_word = 8'h60;
        drain_timeline("drain2");
        for (int i = 0; i < 12; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit %0d ns", 200000);
        $fatal(1);
    end

endmodule
